// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
// Opcodes, flag bit positions, FSM states and iteration kinds.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOT  = 4'd3,
    OP_ADD  = 4'd4,
    OP_ADDU = 4'd5,
    OP_ADDC = 4'd6,
    OP_SUB  = 4'd7,
    OP_CMP  = 4'd8,
    OP_CMPU = 4'd9,
    OP_MOV  = 4'd10,
    OP_LSH  = 4'd11,
    OP_RSH  = 4'd12,
    OP_ARSH = 4'd13,
    OP_MUL  = 4'd14
  } op_e;

  localparam int FZ = 4;
  localparam int FC = 3;
  localparam int FF = 2;
  localparam int FN = 1;
  localparam int FL = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    IK_NONE = 3'd0,
    IK_LSH  = 3'd1,
    IK_RSH  = 3'd2,
    IK_ARSH = 3'd3,
    IK_MUL  = 3'd4
  } iter_e;

  function automatic iter_e iter_kind(input logic [3:0] o);
    iter_e k;
    k = IK_NONE;
    case (o)
      OP_LSH:  k = IK_LSH;
      OP_RSH:  k = IK_RSH;
      OP_ARSH: k = IK_ARSH;
      OP_MUL:  k = IK_MUL;
      default: k = IK_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Multi-cycle engine: one shift bit or one shift-add step per cycle.
// Non-iterating ops load a zero count and report done the next cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  iter_e            kind_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  localparam int CW = SHW + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  iter_e              kind_q, kind_d;
  logic               c_q, c_d;
  logic               act_q, act_d;
  logic [WIDTH:0]     hsum;

  always_comb begin
    acc_d  = acc_q;
    mc_d   = mc_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    c_d    = c_q;
    act_d  = act_q;
    hsum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
           + (acc_q[0] ? {1'b0, mc_q} : '0);
    if (start_i) begin
      acc_d  = {{WIDTH{1'b0}}, (kind_i == IK_MUL) ? b_i : a_i};
      mc_d   = a_i;
      kind_d = kind_i;
      c_d    = 1'b0;
      act_d  = 1'b1;
      unique case (kind_i)
        IK_MUL:  cnt_d = CW'(WIDTH);
        IK_NONE: cnt_d = '0;
        default: cnt_d = {1'b0, b_i[SHW-1:0]};
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      unique case (kind_q)
        IK_LSH: begin
          c_d = acc_q[WIDTH-1];
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b0};
        end
        IK_RSH: begin
          c_d = acc_q[0];
          acc_d[WIDTH-1:0] = {1'b0, acc_q[WIDTH-1:1]};
        end
        IK_ARSH: begin
          c_d = acc_q[0];
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        end
        // high half accumulates, multiplier drains out of the low half
        IK_MUL:  acc_d = {hsum, acc_q[WIDTH-1:1]};
        default: ;
      endcase
    end else if (act_q) begin
      act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mc_q   <= '0;
      cnt_q  <= '0;
      kind_q <= IK_NONE;
      c_q    <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mc_q   <= mc_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      c_q    <= c_d;
      act_q  <= act_d;
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign done_o  = act_q && (cnt_q == '0);
  assign res_o   = acc_q[WIDTH-1:0];
  assign carry_o = (kind_q == IK_MUL) ? |acc_q[2*WIDTH-1:WIDTH] : c_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshake FSM, single-cycle ops and flag register.
// Shifts and multiply run in alu_iter_unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             upd_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic [4:0]       flags_q
);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             upd_q, cin_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       flg_q, flg_d;
  logic [4:0]       fr_q, fr_d;

  logic             accept;
  logic             it_busy, it_done, it_carry;
  logic [WIDTH-1:0] it_res;

  logic [WIDTH:0]   sum, dif;
  logic             cin_use, slt, ult, ovf_add, ovf_sub;
  logic [WIDTH-1:0] r;
  logic [4:0]       f;
  logic             commit;

  assign accept = in_valid && in_ready;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .kind_i  (iter_kind(op)),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (it_busy),
    .done_o  (it_done),
    .res_o   (it_res),
    .carry_o (it_carry)
  );

  always_comb begin
    cin_use = (op_q == OP_ADDC) && cin_q;
    sum     = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_use);
    dif     = {1'b0, a_q} - {1'b0, b_q};
    slt     = $signed(a_q) < $signed(b_q);
    ult     = a_q < b_q;
    ovf_add = (a_q[WIDTH-1] == b_q[WIDTH-1])
           && (sum[WIDTH-1] != a_q[WIDTH-1]);
    ovf_sub = (a_q[WIDTH-1] != b_q[WIDTH-1])
           && (dif[WIDTH-1] != a_q[WIDTH-1]);
    r = '0;
    f = '0;
    unique case (op_q)
      OP_AND:  r = a_q & b_q;
      OP_OR:   r = a_q | b_q;
      OP_XOR:  r = a_q ^ b_q;
      OP_NOT:  r = ~a_q;
      OP_MOV:  r = a_q;
      OP_ADD, OP_ADDC: begin
        r     = sum[WIDTH-1:0];
        f[FC] = sum[WIDTH];
        f[FF] = ovf_add;
      end
      OP_ADDU: begin
        r     = sum[WIDTH-1:0];
        f[FC] = sum[WIDTH];
        f[FF] = sum[WIDTH];
      end
      OP_SUB: begin
        r     = dif[WIDTH-1:0];
        f[FC] = dif[WIDTH];
        f[FF] = ovf_sub;
        f[FN] = slt;
        f[FL] = ult;
      end
      OP_CMP, OP_CMPU: begin
        f[FN] = (op_q == OP_CMP) && slt;
        f[FL] = ult;
      end
      OP_LSH, OP_RSH, OP_ARSH, OP_MUL: begin
        r     = it_res;
        f[FC] = it_carry;
      end
      default: ;
    endcase
    // compares report equality, undefined ops report nothing
    if (op_q == OP_CMP || op_q == OP_CMPU)
      f[FZ] = (a_q == b_q);
    else if (op_q != 4'hF)
      f[FZ] = (r == '0);
  end

  always_comb begin
    st_d  = st_q;
    res_d = res_q;
    flg_d = flg_q;
    unique case (st_q)
      S_IDLE: if (in_valid) st_d = S_ITER;
      S_ITER: begin
        if (it_done && !it_busy) begin
          st_d  = S_DONE;
          res_d = r;
          flg_d = f;
        end
      end
      S_DONE: if (out_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign commit = (st_q == S_DONE) && out_ready && (op_q != 4'hF)
               && (upd_q || op_q == OP_CMP || op_q == OP_CMPU);
  assign fr_d   = commit ? flg_q : fr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      upd_q <= 1'b0;
      cin_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      fr_q  <= '0;
    end else begin
      st_q  <= st_d;
      res_q <= res_d;
      flg_q <= flg_d;
      fr_q  <= fr_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        upd_q <= upd_flags;
        cin_q <= fr_q[FC];
      end
    end
  end

  assign in_ready  = (st_q == S_IDLE) && !it_busy;
  assign out_valid = (st_q == S_DONE);
  assign result    = res_q;
  assign flags     = flg_q;
  assign flags_q   = fr_q;

endmodule
